// File: rtl/sm_key_debounce_if.sv
// Key bundle between the raw button pins and the conditioned outputs.
// The master drives the raw pins; the debouncer (slave) drives the outputs.
interface sm_key_debounce_if #(
   parameter int KEY_N = 4
);
   logic [KEY_N-1:0] key_raw;
   logic [KEY_N-1:0] key_state;
   logic [KEY_N-1:0] key_press;
   logic [KEY_N-1:0] key_release;
   logic [KEY_N-1:0] key_toggle;

   modport master (
      output key_raw,
      input  key_state,
      input  key_press,
      input  key_release,
      input  key_toggle
   );

   modport slave (
      input  key_raw,
      output key_state,
      output key_press,
      output key_release,
      output key_toggle
   );
endinterface

// File: rtl/sm_key_debounce.sv
// Push-button conditioner: per-key 2-flop sync, stable-count filter,
// one-cycle press/release pulses and a press-toggled latch.
module sm_key_debounce #(
   parameter int KEY_N           = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter bit TOGGLE_INIT     = 1'b0
) (
   input logic               clkIn,
   input logic               rst_n,
   sm_key_debounce_if.slave  bus
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [KEY_N-1:0] lvl;
   logic [KEY_N-1:0] s1;
   logic [KEY_N-1:0] s2;
   logic [KEY_N-1:0] state;
   logic [KEY_N-1:0] press;
   logic [KEY_N-1:0] release_p;
   logic [KEY_N-1:0] toggle;
   logic [CW-1:0]    cnt [KEY_N];

   // Normalised so 1 always means pressed; sync flops then idle at 0.
   assign lvl = ACTIVE_LOW ? ~bus.key_raw : bus.key_raw;

   always_ff @(posedge clkIn or negedge rst_n) begin
      if (!rst_n) begin
         s1        <= '0;
         s2        <= '0;
         state     <= '0;
         press     <= '0;
         release_p <= '0;
         toggle    <= {KEY_N{TOGGLE_INIT}};
         for (int k = 0; k < KEY_N; k++) begin
            cnt[k] <= '0;
         end
      end else begin
         s1        <= lvl;
         s2        <= s1;
         press     <= '0;
         release_p <= '0;
         for (int k = 0; k < KEY_N; k++) begin
            if (s2[k] == state[k]) begin
               cnt[k] <= '0;
            end else if (cnt[k] < CMAX) begin
               cnt[k] <= cnt[k] + 1'b1;
            end else begin
               cnt[k]   <= '0;
               state[k] <= s2[k];
               if (s2[k]) begin
                  press[k]  <= 1'b1;
                  toggle[k] <= ~toggle[k];
               end else begin
                  release_p[k] <= 1'b1;
               end
            end
         end
      end
   end

   assign bus.key_state   = state;
   assign bus.key_press   = press;
   assign bus.key_release = release_p;
   assign bus.key_toggle  = toggle;
endmodule
